// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse MixColumns datapath.
// Coefficients are the InvMixColumns matrix row 0e/0b/0d/09.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  localparam logic [7:0] GF_POLY = 8'h1B;
  localparam logic [3:0] C_E     = 4'hE;
  localparam logic [3:0] C_B     = 4'hB;
  localparam logic [3:0] C_D     = 4'hD;
  localparam logic [3:0] C_9     = 4'h9;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by a coefficient below 16; enough for every InvMixColumns constant.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] coef);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{coef[0]}} & a) ^ ({8{coef[1]}} & x2) ^
           ({8{coef[2]}} & x4) ^ ({8{coef[3]}} & x8);
  endfunction

endpackage

// File: rtl/inv_col_mix.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the top byte.
module inv_col_mix
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_s [4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_row
      assign w_s[g] = i_col[31-8*g -: 8];
      assign o_col[31-8*g -: 8] = gf_mul(w_s[g], C_E)
                                ^ gf_mul(w_s[(g+1)%4], C_B)
                                ^ gf_mul(w_s[(g+2)%4], C_D)
                                ^ gf_mul(w_s[(g+3)%4], C_9);
    end
  endgenerate

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: accepts a 128-bit state, transforms COLS_PER_CYCLE
// columns per busy cycle, and holds the result until the consumer takes it.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [2:0] NCOL3 = 3'(COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  fsm_t           r_state;
  fsm_t           w_state_next;
  logic [2:0]     r_col_cnt;
  logic [2:0]     w_col_cnt_next;
  state_t         r_buf;
  state_t         w_buf_next;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
  logic [3:0][31:0] w_buf_cols;
  logic [3:0][31:0] w_lane_out;
  logic [3:0][31:0] w_xform_cols;

  // Packed element 3 is column 0, matching the MSB-first column layout.
  assign w_buf_cols = r_buf;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      if (g < COLS_PER_CYCLE) begin : g_mix
        logic [1:0] w_idx;
        assign w_idx = r_col_cnt[1:0] + 2'(g);
        inv_col_mix u_inv_col_mix (
          .i_col (w_buf_cols[2'd3 - w_idx]),
          .o_col (w_lane_out[g])
        );
      end else begin : g_idle
        assign w_lane_out[g] = 32'h0;
      end
    end
  endgenerate

  // Merge the lane results back into the columns they were taken from.
  always_comb begin
    logic [1:0] off;
    w_xform_cols = w_buf_cols;
    off          = 2'd0;
    for (int c = 0; c < 4; c++) begin
      off = 2'(c) - r_col_cnt[1:0];
      if ({1'b0, off} < NCOL3) begin
        w_xform_cols[2'd3 - 2'(c)] = w_lane_out[off];
      end else begin
        w_xform_cols[2'd3 - 2'(c)] = w_buf_cols[2'd3 - 2'(c)];
      end
    end
  end

  // Next-state, column counter and buffer update.
  always_comb begin
    w_state_next   = r_state;
    w_col_cnt_next = r_col_cnt;
    w_buf_next     = r_buf;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_buf_next     = in_state;
          w_col_cnt_next = 3'd0;
          w_state_next   = in_bypass ? ST_DONE : ST_BUSY;
        end else begin
          w_state_next   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_buf_next     = w_xform_cols;
        w_col_cnt_next = r_col_cnt + NCOL3;
        if (w_col_cnt_next == 3'd4) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col_cnt   <= 3'd0;
      r_buf       <= 128'h0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_col_cnt   <= w_col_cnt_next;
      r_buf       <= w_buf_next;
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_out_valid <= (w_state_next == ST_DONE);
      r_busy      <= (w_state_next == ST_BUSY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_state = r_buf;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and scoreboard bench for inv_mix_columns_seq at 1 and 4 columns/cycle.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_ready;
  logic         in_ready_1, out_valid_1, busy_1;
  logic [127:0] out_state_1;
  logic         in_ready_4, out_valid_4, busy_4;
  logic [127:0] out_state_4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_state(out_state_1), .busy(busy_1)
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid_4),
    .out_ready(out_ready), .out_state(out_state_4), .busy(busy_4)
  );

  typedef struct {
    logic [127:0] din;
    logic         bypass;
    logic [127:0] exp;
    int           lat1;
    int           lat4;
    int           busy1;
    int           busy4;
  } vec_t;

  vec_t vecs[5];

  // Independent reference: explicit per-coefficient xtime chains.
  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return m2(m2(m2(a))) ^ m2(m2(a)) ^ m2(a);
  endfunction
  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return m2(m2(m2(a))) ^ m2(a) ^ a;
  endfunction
  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return m2(m2(m2(a))) ^ m2(m2(a)) ^ a;
  endfunction
  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return m2(m2(m2(a))) ^ a;
  endfunction
  function automatic logic [31:0] ref_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {mul_e(s0) ^ mul_b(s1) ^ mul_d(s2) ^ mul_9(s3),
            mul_e(s1) ^ mul_b(s2) ^ mul_d(s3) ^ mul_9(s0),
            mul_e(s2) ^ mul_b(s3) ^ mul_d(s0) ^ mul_9(s1),
            mul_e(s3) ^ mul_b(s0) ^ mul_d(s1) ^ mul_9(s2)};
  endfunction
  function automatic logic [127:0] ref_state(input logic [127:0] st, input logic byp);
    if (byp) return st;
    return {ref_col(st[127:96]), ref_col(st[95:64]), ref_col(st[63:32]), ref_col(st[31:0])};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat1 = 0, lat4 = 0, b1 = 0, b4 = 0;
    logic [127:0] res1 = '0, res4 = '0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_state  = v.din;
    in_bypass = v.bypass;
    out_ready = 1'b1;
    chk($sformatf("v%0d_in_ready", idx), 128'(in_ready_1 & in_ready_4), 128'(1));
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      #1;
      if (n == 1) begin
        in_valid  = 1'b0;
        in_state  = ~v.din;
        in_bypass = ~v.bypass;
      end
      if (busy_1) b1++;
      if (busy_4) b4++;
      if (out_valid_1 && lat1 == 0) begin lat1 = n; res1 = out_state_1; end
      if (out_valid_4 && lat4 == 0) begin lat4 = n; res4 = out_state_4; end
      @(posedge clk);
    end
    chk($sformatf("v%0d_result_c1", idx), res1, v.exp);
    chk($sformatf("v%0d_result_c4", idx), res4, v.exp);
    chk($sformatf("v%0d_latency_c1", idx), 128'(lat1), 128'(v.lat1));
    chk($sformatf("v%0d_latency_c4", idx), 128'(lat4), 128'(v.lat4));
    chk($sformatf("v%0d_busy_c1", idx), 128'(b1), 128'(v.busy1));
    chk($sformatf("v%0d_busy_c4", idx), 128'(b4), 128'(v.busy4));
  endtask

  initial begin
    logic [127:0] q1[$];
    logic [127:0] q4[$];
    logic         overlap;
    int           t;

    vecs[0] = '{din: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, bypass: 1'b0,
                exp: 128'hdb135345_f20a225c_01010101_c6c6c6c6, lat1: 5, lat4: 2, busy1: 4, busy4: 1};
    vecs[1] = '{din: 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, bypass: 1'b0,
                exp: 128'hd4d4d4d5_2d26314c_00000000_ffffffff, lat1: 5, lat4: 2, busy1: 4, busy4: 1};
    vecs[2] = '{din: 128'h01010101_8e4da1bc_c6c6c6c6_9fdc589d, bypass: 1'b0,
                exp: 128'h01010101_db135345_c6c6c6c6_f20a225c, lat1: 5, lat4: 2, busy1: 4, busy4: 1};
    vecs[3] = '{din: 128'h00112233_44556677_8899aabb_ccddeeff, bypass: 1'b1,
                exp: 128'h00112233_44556677_8899aabb_ccddeeff, lat1: 1, lat4: 1, busy1: 0, busy4: 0};
    vecs[4] = '{din: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, bypass: 1'b1,
                exp: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, lat1: 1, lat4: 1, busy1: 0, busy4: 0};

    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'({in_ready_1, in_ready_4}), 128'(2'b11));
    chk("rst_out_valid", 128'({out_valid_1, out_valid_4}), 128'(2'b00));
    chk("rst_busy", 128'({busy_1, busy_4}), 128'(2'b00));
    chk("rst_out_state", out_state_1 | out_state_4, 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Backpressure: hold out_ready low for 10 DONE cycles while junk is offered.
    @(negedge clk);
    in_valid = 1'b1; in_state = vecs[1].din; in_bypass = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid_1 && t < 10) begin @(posedge clk); #1; t++; end
    chk("bp_reach_done", 128'(out_valid_1), 128'(1));
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom}; in_bypass = 1'b1;
      chk("bp_out_valid", 128'(out_valid_1), 128'(1));
      chk("bp_out_state", out_state_1, vecs[1].exp);
      chk("bp_in_ready", 128'(in_ready_1), 128'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid_1), 128'(0));
    chk("bp_release_ready", 128'(in_ready_1), 128'(1));

    // Reset during the second BUSY cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_state = vecs[0].din; in_bypass = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy_before_rst", 128'(busy_1), 128'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 128'(in_ready_1), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid_1), 128'(0));
    chk("mid_rst_out_state", out_state_1, 128'h0);
    chk("mid_rst_busy", 128'(busy_1), 128'(0));
    overlap = 1'b0;
    repeat (6) begin @(posedge clk); #1; overlap = overlap | out_valid_1; end
    chk("mid_rst_no_result", 128'(overlap), 128'(0));
    run_vec(vecs[2], 5);

    // Random traffic with scoreboards on both instances.
    overlap = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      in_bypass = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      overlap = overlap | (in_ready_1 & out_valid_1) | (in_ready_4 & out_valid_4);
      if (out_valid_1 && out_ready) begin
        if (q1.size() == 0) chk("rnd_c1_unexpected", 128'(1), 128'(0));
        else chk("rnd_c1_result", out_state_1, q1.pop_front());
      end
      if (out_valid_4 && out_ready) begin
        if (q4.size() == 0) chk("rnd_c4_unexpected", 128'(1), 128'(0));
        else chk("rnd_c4_result", out_state_4, q4.pop_front());
      end
      if (in_valid && in_ready_1) q1.push_back(ref_state(in_state, in_bypass));
      if (in_valid && in_ready_4) q4.push_back(ref_state(in_state, in_bypass));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (out_valid_1) begin
        if (q1.size() == 0) chk("drain_c1_unexpected", 128'(1), 128'(0));
        else chk("drain_c1_result", out_state_1, q1.pop_front());
      end
      if (out_valid_4) begin
        if (q4.size() == 0) chk("drain_c4_unexpected", 128'(1), 128'(0));
        else chk("drain_c4_result", out_state_4, q4.pop_front());
      end
      @(negedge clk);
    end
    chk("rnd_ready_valid_overlap", 128'(overlap), 128'(0));
    chk("rnd_pending_c1", 128'(q1.size()), 128'(0));
    chk("rnd_pending_c4", 128'(q4.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_seq.md
INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 Parameter: COLS_PER_CYCLE, default 1, columns transformed per busy cycle; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: in_valid  input  1  upstream presents a 128-bit state.
REQ-005 Port: in_ready  output  1  block can accept a state.
REQ-006 Port: in_state  input  128  AES state; column c = bits [127-32c : 96-32c]; row 0 = most significant byte of each column.
REQ-007 Port: in_bypass  input  1  sampled with in_state; 1 = pass the state through untransformed (final decryption round).
REQ-008 Port: out_valid  output  1  out_state holds a completed result.
REQ-009 Port: out_ready  input  1  downstream accepts the result.
REQ-010 Port: out_state  output  128  transformed state, same column/row layout as in_state.
REQ-011 Port: busy  output  1  high while in BUSY.

Function
REQ-012 States: IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==BUSY).
REQ-013 Accept = in_valid && in_ready; on accept, capture in_state into the internal state buffer and clear col_cnt to 0.
REQ-014 On accept with in_bypass=0: next state BUSY; with in_bypass=1: next state DONE, buffer unchanged.
REQ-015 In each BUSY cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the buffer with their InvMixColumns result, then advance col_cnt by COLS_PER_CYCLE.
REQ-016 Per column with bytes s0..s3 (row 0..3), result r_i = 0e*s_i ^ 0b*s_(i+1) ^ 0d*s_(i+2) ^ 09*s_(i+3), indices mod 4, in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-017 BUSY -> DONE in the cycle that transforms column 3; BUSY length = 4/COLS_PER_CYCLE cycles.
REQ-018 Latency: out_valid rises 4/COLS_PER_CYCLE + 1 rising edges after the accept edge (1 edge when bypassed).
REQ-019 In DONE, out_state SHALL hold stable until out_valid && out_ready; that edge returns to IDLE.
REQ-020 in_ready SHALL NOT be asserted in the same cycle as out_valid; throughput = one state per 4/COLS_PER_CYCLE + 2 cycles.
REQ-021 in_valid, in_state and in_bypass are ignored outside IDLE; changing them mid-operation SHALL NOT affect the result.
REQ-022 out_ready held low indefinitely SHALL stall in DONE with no data loss; out_ready outside DONE is ignored.
REQ-023 out_state SHALL always reflect the internal buffer; its value is defined to consumers only while out_valid=1.

Reset
REQ-024 While rst_n=0 at a rising edge: state = IDLE, col_cnt = 0, buffer = 0; out_valid = 0, busy = 0, out_state = 0, in_ready = 1 after the edge.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation; the partial or pending result is discarded and no out_valid is produced for it.

Structure
REQ-026 Shared package aes_pkg: typedef for the 128-bit state and 32-bit column, the state-machine enum, GF(2^8) reduction constant 8'h1B, and the column-multiplier coefficients 0e/0b/0d/09.
REQ-027 One combinational sub-module, inv_col_mix (32-bit column in, 32-bit column out, per REQ-016), SHALL be instantiated COLS_PER_CYCLE times; the column select is muxed by col_cnt.

Verification
REQ-028 Single column: in_state = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}, bypass=0 -> out_state = {db135345, f20a225c, 01010101, c6c6c6c6}.
REQ-029 Latency: COLS_PER_CYCLE=1 -> out_valid 5 edges after accept; COLS_PER_CYCLE=4 -> 2 edges; busy high for exactly 4 and 1 cycles respectively.
REQ-030 Bypass: in_bypass=1, in_state = 00112233_44556677_8899aabb_ccddeeff -> same value on out_state one edge after accept, busy never high.
REQ-031 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0 throughout; result accepted on the first out_ready=1 edge.
REQ-032 Reset mid-operation: rst_n=0 on the 2nd BUSY cycle -> next cycle IDLE, in_ready=1, out_valid=0, out_state=0; a following operation gives the correct result.
REQ-033 Random back-to-back states with in_valid toggling during BUSY -> each result matches a reference model of REQ-016, and no input is accepted outside IDLE.
